ps2_host_tx: RTL

Host-to-device PS/2 transmitter for the Connect Four top level. It is the send side of the keyboard link that the PS/2 receive path already decodes. It sends one command byte to the keyboard, for example 0xED (set LEDs) or 0xFF (reset), using the standard inhibit / request-to-send / device-clocked sequence. It drives the bidirectional PS2_CLK and PS2_DAT pads open-drain through output-enables and reports done or error to the game controller.

---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_line_sync.sv | 28 ++
 rtl/ps2_host_tx.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, error codes and keyboard byte values.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    TX,
    ACK,
    WAIT_IDLE
  } ps2_state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_NACK    = 2'b10;

  localparam logic [7:0] KEY_SPACE    = 8'h29;
  localparam logic [7:0] KEY_ENTER    = 8'h5A;
  localparam logic [7:0] KEY_BKSP     = 8'h66;
  localparam logic [7:0] KEY_BREAK    = 8'hF0;
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] RSP_ACK      = 8'hFA;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one PS/2 pad plus a registered falling-edge detector.
module ps2_line_sync (
  input  logic clk,
  input  logic resetn,
  input  logic pad,
  output logic level,
  output logic fe
);

  logic meta_p0, sync_p1, prev_p2;

  // Idle lines are high, so reset to 1 to avoid a phantom edge after reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      meta_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      prev_p2 <= 1'b1;
    end else begin
      meta_p0 <= pad;
      sync_p1 <= meta_p0;
      prev_p2 <= sync_p1;
    end
  end

  assign level = sync_p1;
  assign fe    = prev_p2 & ~sync_p1;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter; pads are driven open-drain via the two oe outputs.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       send,
  input  logic [7:0] cmd,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic clk_lvl, clk_fe, dat_lvl, dat_fe;

  ps2_line_sync u_clk_sync (.clk(clk), .resetn(resetn), .pad(ps2_clk_in), .level(clk_lvl), .fe(clk_fe));
  ps2_line_sync u_dat_sync (.clk(clk), .resetn(resetn), .pad(ps2_dat_in), .level(dat_lvl), .fe(dat_fe));

  ps2_state_t       state_q, state_d;
  logic [INH_W-1:0] inh_q, inh_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [9:0]       shreg_q, shreg_d;
  logic [3:0]       bit_q, bit_d;
  logic             dat_q, dat_d;
  logic             done_q, done_d, error_q, error_d;
  logic [1:0]       code_q, code_d;
  logic             unused_dat_fe;

  assign unused_dat_fe = dat_fe;

  always_comb begin
    state_d = state_q;
    inh_d   = inh_q;
    tmo_d   = tmo_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    dat_d   = dat_q;
    done_d  = 1'b0;
    error_d = 1'b0;
    code_d  = code_q;
    unique case (state_q)
      IDLE: begin
        // The pulse cycle counts as the tail of the previous transfer.
        if (send && !done_q && !error_q) begin
          shreg_d = {1'b1, odd_parity(cmd), cmd};
          code_d  = ERR_NONE;
          inh_d   = '0;
          bit_d   = '0;
          dat_d   = 1'b0;
          state_d = INHIBIT;
        end
      end
      INHIBIT: begin
        if (inh_q == INH_LAST) begin
          dat_d   = 1'b1;
          tmo_d   = '0;
          state_d = TX;
        end else begin
          inh_d = inh_q + 1'b1;
        end
      end
      TX: begin
        // Shift order: cmd[0..7], parity, stop; the stop bit (1) releases data.
        if (clk_fe) begin
          dat_d   = ~shreg_q[0];
          shreg_d = {1'b0, shreg_q[9:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 4'd9) state_d = ACK;
        end
      end
      ACK: begin
        if (clk_fe) begin
          if (!dat_lvl) begin
            state_d = WAIT_IDLE;
          end else begin
            error_d = 1'b1;
            code_d  = ERR_NACK;
            state_d = IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (clk_lvl && dat_lvl) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_q == TX || state_q == ACK || state_q == WAIT_IDLE) begin
      if (tmo_q != '1) tmo_d = tmo_q + 1'b1;
      if (tmo_q == TMO_LAST && !done_d && !error_d) begin
        error_d = 1'b1;
        code_d  = ERR_TIMEOUT;
        state_d = IDLE;
      end
    end
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      inh_q   <= '0;
      tmo_q   <= '0;
      bit_q   <= '0;
      dat_q   <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      inh_q   <= inh_d;
      tmo_q   <= tmo_d;
      bit_q   <= bit_d;
      dat_q   <= dat_d;
      done_q  <= done_d;
      error_q <= error_d;
      code_q  <= code_d;
    end
  end

  // Frame data register
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

  assign ps2_clk_oe = (state_q == INHIBIT);
  assign ps2_dat_oe = (state_q == INHIBIT) ? (inh_q == INH_LAST)
                                           : ((state_q == TX || state_q == ACK) && dat_q);
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign error    = error_q;
  assign err_code = code_q;

endmodule
